// File: rtl/cp0_regfile.sv
// MIPS CP0 register file: Status/Cause/EPC/BadVAddr/Count/Compare, exception commit,
// eret handling, Count/Compare timer, and pipeline flush/redirect generation.
module cp0_regfile #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int unsigned COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o,
    output logic        flush_o,
    output logic [31:0] newpc_o
);

    localparam logic [4:0]  REG_BADVADDR = 5'd8;
    localparam logic [4:0]  REG_COUNT    = 5'd9;
    localparam logic [4:0]  REG_COMPARE  = 5'd11;
    localparam logic [4:0]  REG_STATUS   = 5'd12;
    localparam logic [4:0]  REG_CAUSE    = 5'd13;
    localparam logic [4:0]  REG_EPC      = 5'd14;
    localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
    localparam logic [31:0] EXC_NONE     = 32'h0000_0000;
    localparam logic [31:0] EXC_INT      = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL     = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES     = 32'h0000_0005;
    localparam logic [31:0] EXC_ERET     = 32'h0000_000E;
    localparam bit          DIV2         = (COUNT_DIV == 2);

    logic [31:0] status_q, cause_q, epc_q, count_q, compare_q, badvaddr_q;
    logic        timer_q, div_q;

    logic        is_exc, is_eret, take_exc, wr_en, tick, exl;
    logic [4:0]  exc_code;

    always_comb begin
        is_exc   = (excepttype_i != EXC_NONE);
        is_eret  = (excepttype_i == EXC_ERET);
        take_exc = is_exc && !is_eret;
        // the faulting/returning instruction must not commit its own mtc0
        wr_en    = we_i && !is_exc;
        exc_code = (excepttype_i == EXC_INT) ? 5'd0 : excepttype_i[4:0];
        exl      = status_q[1];
        tick     = !DIV2 || div_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q   <= STATUS_RST;
            cause_q    <= '0;
            epc_q      <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            badvaddr_q <= '0;
            timer_q    <= 1'b0;
            div_q      <= 1'b0;
        end else begin
            cause_q[15:10] <= int_i;

            if (wr_en && waddr_i == REG_COUNT) begin
                count_q <= data_i;
                div_q   <= 1'b0;
            end else begin
                div_q <= DIV2 ? ~div_q : 1'b0;
                if (tick) count_q <= count_q + 32'd1;
            end

            if (wr_en && waddr_i == REG_COMPARE) compare_q <= data_i;

            // Compare write acknowledges the timer and beats a same-cycle match
            if (wr_en && waddr_i == REG_COMPARE)
                timer_q <= 1'b0;
            else if (compare_q != 32'd0 && count_q == compare_q)
                timer_q <= 1'b1;

            if (take_exc) begin
                status_q[1]   <= 1'b1;
                cause_q[6:2]  <= exc_code;
                if (!exl) begin
                    epc_q       <= in_delayslot_i ? pc_i - 32'd4 : pc_i;
                    cause_q[31] <= in_delayslot_i;
                end
                if (excepttype_i == EXC_ADEL || excepttype_i == EXC_ADES)
                    badvaddr_q <= bad_addr_i;
            end else if (is_eret) begin
                status_q[1] <= 1'b0;
            end else if (wr_en) begin
                case (waddr_i)
                    REG_STATUS: status_q <= (status_q & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
                    REG_CAUSE:  cause_q[9:8] <= data_i[9:8];
                    REG_EPC:    epc_q <= data_i;
                    default:    ;
                endcase
            end
        end
    end

    always_comb begin
        status_o    = status_q;
        cause_o     = {cause_q[31], timer_q, cause_q[29:0]};
        epc_o       = epc_q;
        count_o     = count_q;
        compare_o   = compare_q;
        badvaddr_o  = badvaddr_q;
        timer_int_o = timer_q;
        flush_o     = is_exc;
        newpc_o     = is_eret ? epc_q : EXC_VECTOR;
    end

    // mfc0 read port; unmapped numbers read as zero
    always_comb begin
        data_o = 32'd0;
        case (raddr_i)
            REG_BADVADDR: data_o = badvaddr_q;
            REG_COUNT:    data_o = count_q;
            REG_COMPARE:  data_o = compare_q;
            REG_STATUS:   data_o = status_q;
            REG_CAUSE:    data_o = cause_o;
            REG_EPC:      data_o = epc_q;
            default:      data_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: exception commit, eret, mtc0/mfc0, timer, reset.
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i, raddr_i;
    logic [31:0] data_i, excepttype_i, pc_i, bad_addr_i;
    logic [5:0]  int_hw, int_i;
    logic        in_delayslot_i;
    logic [31:0] data_o, status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o, newpc_o;
    logic        timer_int_o, flush_o;

    int nvec = 0;
    int nerr = 0;

    // SoC-style loopback: timer interrupt shares HW5
    assign int_i = {int_hw[5] | timer_int_o, int_hw[4:0]};

    cp0_regfile #(.EXC_VECTOR(32'hBFC0_0380), .COUNT_DIV(2)) dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
        .data_i(data_i), .int_i(int_i), .excepttype_i(excepttype_i), .pc_i(pc_i),
        .in_delayslot_i(in_delayslot_i), .bad_addr_i(bad_addr_i), .data_o(data_o),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .count_o(count_o),
        .compare_o(compare_o), .badvaddr_o(badvaddr_o), .timer_int_o(timer_int_o),
        .flush_o(flush_o), .newpc_o(newpc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_i = 1'b0; waddr_i = 5'd0; data_i = 32'd0;
        excepttype_i = 32'd0; pc_i = 32'd0; in_delayslot_i = 1'b0; bad_addr_i = 32'd0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; data_i = d;
        tick();
        idle();
    endtask

    initial begin
        rst = 1'b1; int_hw = 6'd0; raddr_i = 5'd0;
        idle();
        #3;
        chk("rst_status", status_o, 32'h0040_0000);
        chk("rst_cause", cause_o, 32'h0);
        chk("rst_count", count_o, 32'h0);
        chk("rst_flush", {31'd0, flush_o}, 32'h0);
        #9 rst = 1'b0;
        tick();

        // Sys, not in a delay slot
        excepttype_i = 32'h8; pc_i = 32'hBFC0_0100;
        #1;
        chk("sys_flush", {31'd0, flush_o}, 32'h1);
        chk("sys_newpc", newpc_o, 32'hBFC0_0380);
        tick(); idle();
        chk("sys_epc", epc_o, 32'hBFC0_0100);
        chk("sys_status", status_o, 32'h0040_0002);
        chk("sys_cause", cause_o, 32'h0000_0020);
        raddr_i = 5'd14; #1;
        chk("mfc0_epc", data_o, 32'hBFC0_0100);
        raddr_i = 5'd5; #1;
        chk("mfc0_unmapped", data_o, 32'h0);

        // eret returns to EPC and clears EXL
        excepttype_i = 32'hE; #1;
        chk("eret1_newpc", newpc_o, 32'hBFC0_0100);
        tick(); idle();
        chk("eret1_status", status_o, 32'h0040_0000);

        // AdEL in delay slot
        excepttype_i = 32'h4; pc_i = 32'hBFC0_0204; in_delayslot_i = 1'b1; bad_addr_i = 32'h3;
        tick(); idle();
        chk("adel_epc", epc_o, 32'hBFC0_0200);
        chk("adel_cause", cause_o, 32'h8000_0010);
        chk("adel_badvaddr", badvaddr_o, 32'h0000_0003);

        // nested Ov while EXL=1: EPC/BD frozen
        excepttype_i = 32'hC; pc_i = 32'hBFC0_0400;
        tick(); idle();
        chk("ov_epc", epc_o, 32'hBFC0_0200);
        chk("ov_cause", cause_o, 32'h8000_0030);
        chk("ov_badvaddr", badvaddr_o, 32'h0000_0003);

        // eret with same-cycle mtc0 EPC: old EPC used, write dropped
        excepttype_i = 32'hE; we_i = 1'b1; waddr_i = 5'd14; data_i = 32'h1234_5678; #1;
        chk("eret2_newpc", newpc_o, 32'hBFC0_0200);
        tick(); idle();
        chk("eret2_status", status_o, 32'h0040_0000);
        chk("eret2_epc", epc_o, 32'hBFC0_0200);

        // masked mtc0 writes
        mtc0(5'd12, 32'hFFFF_FFFF);
        chk("wr_status_all", status_o, 32'h0040_FF03);
        mtc0(5'd12, 32'h0000_0101);
        chk("wr_status", status_o, 32'h0040_0101);
        mtc0(5'd13, 32'hFFFF_FFFF);
        chk("wr_cause", cause_o, 32'h8000_0330);
        int_hw = 6'b000101;
        tick();
        chk("int_sample", cause_o, 32'h8000_1730);
        int_hw = 6'd0;
        tick();

        // timer: Count=0 then Compare=10
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd10);
        chk("tmr_count0", count_o, 32'd0);
        repeat (19) tick();
        chk("tmr_count10", count_o, 32'd10);
        chk("tmr_pre", {31'd0, timer_int_o}, 32'h0);
        tick();
        chk("tmr_fire", {31'd0, timer_int_o}, 32'h1);
        chk("tmr_ti", {31'd0, cause_o[30]}, 32'h1);
        tick();
        chk("tmr_ip7", {31'd0, cause_o[15]}, 32'h1);
        mtc0(5'd11, 32'h100);
        chk("tmr_clear", {31'd0, timer_int_o}, 32'h0);
        tick();

        // mtc0 Status dropped under same-cycle Ov
        excepttype_i = 32'hC; pc_i = 32'hBFC0_0500; we_i = 1'b1; waddr_i = 5'd12; data_i = 32'h0;
        tick(); idle();
        chk("drop_status", status_o, 32'h0040_0103);
        chk("drop_epc", epc_o, 32'hBFC0_0500);
        chk("drop_cause", cause_o, 32'h0000_0330);

        // Count wrap
        mtc0(5'd9, 32'hFFFF_FFFF);
        chk("wrap_load", count_o, 32'hFFFF_FFFF);
        tick();
        chk("wrap_hold", count_o, 32'hFFFF_FFFF);
        tick();
        chk("wrap_zero", count_o, 32'h0);

        // unknown code and Int
        excepttype_i = 32'h3; #1;
        chk("unk_flush", {31'd0, flush_o}, 32'h1);
        tick(); idle();
        chk("unk_exccode", {27'd0, cause_o[6:2]}, 32'h3);
        chk("unk_badvaddr", badvaddr_o, 32'h0000_0003);
        excepttype_i = 32'h1;
        tick(); idle();
        chk("int_exccode", {27'd0, cause_o[6:2]}, 32'h0);

        // asynchronous reset mid-cycle
        @(posedge clk); #3;
        rst = 1'b1; #1;
        chk("arst_status", status_o, 32'h0040_0000);
        chk("arst_epc", epc_o, 32'h0);
        chk("arst_cause", cause_o, 32'h0);
        chk("arst_badvaddr", badvaddr_o, 32'h0);
        chk("arst_flush", {31'd0, flush_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
